// File: rtl/dot_product_engine_if.sv
// Operand, control and byte-serial result bus of the dot-product engine.
// The engine sits on the slave side; the operand loaders and output consumer form the master side.
interface dot_product_engine_if #(
  parameter int N_ELEM   = 16,
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 2,
  parameter int ACC_W    = 16
);
  logic                         start;
  logic [N_ELEM*WEIGHT_W-1:0]   weights;
  logic [N_ELEM*DATA_W-1:0]     data;
  logic                         busy;
  logic                         done;
  logic [ACC_W-1:0]             result;
  logic [7:0]                   out_byte;
  logic                         out_valid;
  logic                         out_ready;

  modport master (
    output start, weights, data, out_ready,
    input  busy, done, result, out_byte, out_valid
  );

  modport slave (
    input  start, weights, data, out_ready,
    output busy, done, result, out_byte, out_valid
  );
endinterface

// File: rtl/dot_product_engine.sv
// Sequential signed MAC over snapshotted weight/data vectors, one element per cycle,
// followed by LSB-first byte-serial streaming of the result over valid/ready.
module dot_product_engine #(
  parameter int N_ELEM   = 16,
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 2,
  parameter int ACC_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  dot_product_engine_if.slave  bus
);
  localparam int N_BYTES = ACC_W / 8;
  localparam int IDX_W   = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam int K_W     = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);
  localparam logic [K_W-1:0]   LAST_K   = K_W'(N_BYTES - 1);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                      state_q, state_d;
  logic [N_ELEM*WEIGHT_W-1:0]  w_snap_q, w_snap_d;
  logic [N_ELEM*DATA_W-1:0]    d_snap_q, d_snap_d;
  logic [ACC_W-1:0]            acc_q, acc_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [K_W-1:0]              k_q, k_d;
  logic [ACC_W-1:0]            result_q, result_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        out_valid_q, out_valid_d;
  logic [7:0]                  out_byte_q, out_byte_d;

  logic [WEIGHT_W-1:0]         w_elem [N_ELEM];
  logic [DATA_W-1:0]           d_elem [N_ELEM];
  logic [7:0]                  res_byte [N_BYTES];
  logic [WEIGHT_W-1:0]         w_cur;
  logic [DATA_W-1:0]           d_cur;
  logic [ACC_W-1:0]            w_ext, d_ext, prod, mac_sum;
  logic                        handshake;

  genvar gi;
  generate
    for (gi = 0; gi < N_ELEM; gi++) begin : g_elem
      assign w_elem[gi] = w_snap_q[gi*WEIGHT_W +: WEIGHT_W];
      assign d_elem[gi] = d_snap_q[gi*DATA_W +: DATA_W];
    end
    for (gi = 0; gi < N_BYTES; gi++) begin : g_byte
      assign res_byte[gi] = result_d[gi*8 +: 8];
    end
  endgenerate

  // A single multiplier, time-shared across elements; products wrap at ACC_W bits.
  assign w_cur     = w_elem[idx_q];
  assign d_cur     = d_elem[idx_q];
  assign w_ext     = {{(ACC_W-WEIGHT_W){w_cur[WEIGHT_W-1]}}, w_cur};
  assign d_ext     = {{(ACC_W-DATA_W){d_cur[DATA_W-1]}}, d_cur};
  assign prod      = w_ext * d_ext;
  assign mac_sum   = acc_q + prod;
  assign handshake = (state_q == OUT) && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = MAC;
      MAC:     if (idx_q == LAST_IDX) state_d = OUT;
      OUT:     if (handshake && (k_q == LAST_K)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    w_snap_d = w_snap_q;
    d_snap_d = d_snap_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    k_d      = k_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          w_snap_d = bus.weights;
          d_snap_d = bus.data;
          acc_d    = '0;
          idx_d    = '0;
          result_d = '0;
        end
      end
      MAC: begin
        acc_d = mac_sum;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          result_d = mac_sum;
          k_d      = '0;
        end
      end
      OUT: begin
        if (handshake) k_d = (k_q == LAST_K) ? '0 : k_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs are decoded from next-state values so they can be registered without extra latency.
  always_comb begin
    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == OUT);
    out_byte_d  = out_valid_d ? res_byte[k_d] : 8'h00;
    done_d      = (state_q == OUT) && (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_snap_q    <= '0;
      d_snap_q    <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      k_q         <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_byte_q  <= 8'h00;
    end else begin
      w_snap_q    <= w_snap_d;
      d_snap_q    <= d_snap_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      k_q         <= k_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_byte_q  <= out_byte_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_byte  = out_byte_q;
endmodule

// File: tb/tb_dot_product_engine.sv
// Directed self-checking bench for dot_product_engine with hand-computed expected results.
module tb_dot_product_engine;
  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [127:0] D_INC = 128'h100F0E0D0C0B0A09_0807060504030201;

  dot_product_engine_if #(.N_ELEM(16), .DATA_W(8), .WEIGHT_W(2), .ACC_W(16)) bus ();

  dot_product_engine #(.N_ELEM(16), .DATA_W(8), .WEIGHT_W(2), .ACC_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      n_checks++;
      if ({bus.busy, bus.done, bus.out_valid, bus.result, bus.out_byte} !== 27'd0) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: busy=%b done=%b valid=%b result=%h byte=%h, want all zero",
                 c, bus.busy, bus.done, bus.out_valid, bus.result, bus.out_byte);
      end
      tick();
    end
    $display("reset_idle: 20 idle cycles observed");
  endtask

  // Starts one computation and drains it; returns during the done cycle so a
  // following call exercises a back-to-back start.
  task automatic run_op(input string nm, input logic [31:0] w, input logic [127:0] d,
                        input logic [15:0] exp_res, input int stall, input int exp_lat);
    int cyc;
    bus.weights   = w;
    bus.data      = d;
    bus.start     = 1'b1;
    bus.out_ready = (stall == 0);
    tick();
    cyc = 0;
    bus.start   = 1'b0;
    bus.weights = ~w;
    bus.data    = ~d;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s start: busy=%b done=%b, want busy=1 done=0", nm, bus.busy, bus.done);
    end
    while (bus.out_valid !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc !== 16) begin
      n_fail++;
      $display("FAIL %s valid_latency: got %0d cycles, want 16", nm, cyc);
    end
    n_checks++;
    if (bus.result !== exp_res) begin
      n_fail++;
      $display("FAIL %s result: got %h, want %h", nm, bus.result, exp_res);
    end
    for (int bi = 0; bi < 2; bi++) begin
      for (int s = 0; s < stall; s++) begin
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_byte !== exp_res[bi*8 +: 8]) begin
          n_fail++;
          $display("FAIL %s stall_byte%0d: valid=%b byte=%h, want valid=1 byte=%h",
                   nm, bi, bus.out_valid, bus.out_byte, exp_res[bi*8 +: 8]);
        end
        tick();
        cyc++;
      end
      bus.out_ready = 1'b1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_byte !== exp_res[bi*8 +: 8]) begin
        n_fail++;
        $display("FAIL %s byte%0d: valid=%b byte=%h, want valid=1 byte=%h",
                 nm, bi, bus.out_valid, bus.out_byte, exp_res[bi*8 +: 8]);
      end
      tick();
      cyc++;
    end
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_byte !== 8'h00) begin
      n_fail++;
      $display("FAIL %s done: done=%b busy=%b valid=%b byte=%h, want 1 0 0 00",
               nm, bus.done, bus.busy, bus.out_valid, bus.out_byte);
    end
    n_checks++;
    if (cyc !== exp_lat) begin
      n_fail++;
      $display("FAIL %s done_latency: got %0d cycles, want %0d", nm, cyc, exp_lat);
    end
    $display("%s: w=%h result=%h latency=%0d", nm, w, bus.result, cyc);
  endtask

  task automatic test_basic();
    run_op("pos_ones", 32'h5555_5555, D_INC, 16'h0088, 0, 18);
  endtask

  task automatic test_back_to_back();
    run_op("neg_two", 32'hAAAA_AAAA, {16{8'h80}}, 16'h1000, 0, 18);
    run_op("neg_one_stall", 32'hFFFF_FFFF, {16{8'h7F}}, 16'hF810, 3, 24);
  endtask

  task automatic test_start_ignored();
    int done_cnt = 0;
    tick();
    bus.weights   = 32'h5555_5555;
    bus.data      = D_INC;
    bus.start     = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    for (int c = 1; c <= 30; c++) begin
      bus.start     = (c == 5 || c == 17 || c == 19);
      bus.weights   = 32'hFFFF_FFFF;
      bus.data      = {16{8'h7F}};
      bus.out_ready = (c >= 18);
      tick();
      if (bus.done === 1'b1) done_cnt++;
      if (c == 19) begin
        n_checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.result !== 16'h0088) begin
          n_fail++;
          $display("FAIL start_ignored done: done=%b busy=%b result=%h, want 1 0 0088",
                   bus.done, bus.busy, bus.result);
        end
      end
      if (c == 20) begin
        n_checks++;
        if (bus.busy !== 1'b0) begin
          n_fail++;
          $display("FAIL start_ignored last_edge_start: busy=%b, want 0", bus.busy);
        end
      end
    end
    n_checks++;
    if (done_cnt !== 1) begin
      n_fail++;
      $display("FAIL start_ignored done_count: got %0d, want 1", done_cnt);
    end
    $display("start_ignored: result=%h dones=%0d", bus.result, done_cnt);
  endtask

  task automatic test_reset_mid_mac();
    int done_cnt = 0;
    bus.weights   = 32'hFFFF_FFFF;
    bus.data      = {16{8'h7F}};
    bus.start     = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    rst       = 1'b1;
    bus.start = 1'b1;
    tick();
    n_checks++;
    if ({bus.busy, bus.out_valid, bus.done, bus.result, bus.out_byte} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_mid_mac: busy=%b valid=%b done=%b result=%h byte=%h, want all zero",
               bus.busy, bus.out_valid, bus.done, bus.result, bus.out_byte);
    end
    rst       = 1'b0;
    bus.start = 1'b0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_cnt++;
    end
    n_checks++;
    if (done_cnt !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_mac aborted: %0d cycles with done/busy, want 0", done_cnt);
    end
    run_op("after_rst", 32'h0000_FFFF, {16{8'h10}}, 16'hFF80, 0, 18);
    tick();
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.weights   = '0;
    bus.data      = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_mac();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dot_product_engine.md
# dot_product_engine

Downstream consumer of the two serially-loaded operand registers (32-bit weight register, 128-bit data register). On a start strobe it snapshots both registers, performs a sequential signed multiply-accumulate over N elements (one element per cycle), then streams the accumulated result out byte-serially over a valid/ready handshake. It sits between the operand loaders and the chip's 8-bit output bus.

## Interface
- N_ELEM, 16, number of elements per dot product
- DATA_W, 8, signed data element width (two's complement)
- WEIGHT_W, 2, signed weight element width (two's complement: 00=0, 01=+1, 10=-2, 11=-1)
- ACC_W, 16, accumulator/result width; must be a multiple of 8

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a computation; sampled only in IDLE
- weights  input  N_ELEM*WEIGHT_W  weight vector; element i at bits [i*WEIGHT_W +: WEIGHT_W]
- data  input  N_ELEM*DATA_W  data vector; element i at bits [i*DATA_W +: DATA_W]
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse after last result byte accepted
- result  output  ACC_W  final accumulator value, held stable from OUT entry until next start
- out_byte  output  8  current result byte, LSB byte first
- out_valid  output  1  out_byte valid
- out_ready  input  1  consumer accepts out_byte when out_valid && out_ready at a rising edge

## Operation
- States: IDLE, MAC, OUT.
- IDLE: busy=0, out_valid=0. start=1 at an edge -> capture weights/data into internal snapshot registers, acc<=0, idx<=0, result<=0, state<=MAC. Inputs may change freely after capture.
- MAC: each edge acc <= acc + sext(w[idx]) * sext(d[idx]), computed at ACC_W bits, wrapping modulo 2^ACC_W; idx<=idx+1. On the edge processing idx=N_ELEM-1: result<=final sum, byte index<=0, state<=OUT.
- OUT: out_valid=1, out_byte=result[8*k +: 8] for byte index k. On handshake, k<=k+1; handshake on k=ACC_W/8-1 -> state<=IDLE, done<=1 for one cycle.
- start ignored in MAC and OUT (no restart, no snapshot change). start in the cycle the last byte is accepted is ignored (state not yet IDLE).
- out_byte holds its value while out_valid && !out_ready; out_byte undefined-but-stable (drive 0) when out_valid=0.
- rst (any state, any cycle): state<=IDLE, acc, idx, k, result, snapshots <=0; busy=0, done=0, out_valid=0, out_byte=0. Reset dominates a simultaneous start. Reset mid-MAC or mid-OUT aborts with no done pulse.
- Reset value of every output: busy=0, done=0, result=0, out_byte=0, out_valid=0.

## Timing
- Start sampled at edge E0 -> busy high after E0.
- Accumulation on edges E1..E(N_ELEM); out_valid high after E(N_ELEM) (16 cycles for defaults).
- With out_ready held high: bytes accepted at E(N+1)..E(N+ACC_W/8); done high for the single cycle after E(N+ACC_W/8); busy low from that same cycle. Default total: start edge to done = 18 cycles.
- Back-to-back: earliest next start accepted at the edge ending the done cycle.
- Back-pressure: each cycle of out_ready=0 while out_valid=1 delays done by one cycle; no byte lost or duplicated.
- No combinational path from any input to any output except none; all outputs are registered.

## Test plan
- Reset then idle: rst=1 two cycles, start=0 -> all outputs 0, busy=0 for 20 cycles.
- weights=32'h5555_5555 (all +1), data element i = i+1 (1..16), start, out_ready=1 -> result=16'h0088, bytes 0x88 then 0x00, done at 18 cycles after start.
- weights=32'hAAAA_AAAA (all -2), data all 8'h80 (-128) -> result=16'h1000, bytes 0x00, 0x10.
- weights=32'hFFFF_FFFF (all -1), data all 8'h7F -> result=16'hF810; out_ready low 3 cycles before each byte -> bytes 0x10, 0xF8 each held stable while stalled, done delayed by 6 cycles.
- Start pulsed again during MAC and OUT with different weights/data -> ignored; result matches first snapshot; exactly one done.
- rst asserted at cycle 5 of MAC -> next cycle busy=0, out_valid=0, no done; fresh start afterwards yields correct result for new operands.
